lotr_top: RTL and testbench
===========================

Name: lotr_top

Overview:
FPGA top of the LOTR design. It instantiates one 4-thread RV32I tile as instance `gpc_4t_tile_1`, using the existing codebase module gpc_4t_tile, and wraps it with a small memory-mapped FPGA control-register (CR) block. The CR block drives six 7-segment displays and 10 LEDs, and samples 10 switches and 2 push-buttons. This is the board-level top that the FPGA bench instantiates.

Parameters:
CR_BASE, 32'h00C0_0000, byte base address of the FPGA CR window in the tile address space
NUM_SEG7, 6, number of 7-segment digits (fixed at 6)
LED_W, 10, LED and switch width
Memory geometry (I_MEM_OFFSET, SIZE_I_MEM, D_MEM_OFFSET, SIZE_D_MEM, SIZE_SHRD_MEM) comes from lotr_pkg, not from local parameters.

Ports:
QClk  in  1  single clock; every flop is rising-edge
RstQnnnH  in  1  synchronous reset, active-high
Button_0  in  1  board key 0, active-low (0 = pressed); pressed also acts as reset
Button_1  in  1  board key 1, active-low, software-readable only
Switch  in  10  board slide switches
SEG7_0..SEG7_5  out  7 each  segment drives, active-low, bit order {g,f,e,d,c,b,a}
LED  out  10  board LEDs, active-high

Behaviour:
Synchronisers:
- Button_0, Button_1 and Switch each pass through a 2-flop synchroniser.
- The synchroniser flops reset on RstQnnnH only.
- Reset values: buttons 1 (released), switches 0.

Internal reset:
- RstInt = RstQnnnH | ~Button_0_sync.
- RstInt drives the tile's RstQnnnH and all CR registers.
- Any press of Button_0 resets the whole system synchronously, 2 cycles after the press.

Tile hierarchy (required by backdoor loading and memory dumps):
- Path: `gpc_4t_tile_1.gpc_4t.i_mem_wrap.i_mem.{mem,next_mem}` and `gpc_4t_tile_1.gpc_4t.d_mem_wrap.d_mem.{mem,next_mem}`.
- Arrays are byte-wide and are not cleared by reset.

CR interface to the tile:
- Signals: CrAddr[31:0], CrWrEn, CrWrData[31:0], CrRdEn, CrRdData[31:0].
- Writes take effect on the next clock edge.
- Reads return data registered exactly 1 cycle after CrRdEn.
- Simultaneous read and write to the same address returns the old value.
- Addresses outside the map read 0; writes to them are ignored.
- Only word-aligned accesses are decoded; CrAddr[1:0] is ignored.

CR map (offset from CR_BASE):
- 0x00–0x14, SEG7_0..SEG7_5 (RW, 5 bits each): bit4 = enable, bits3:0 = hex digit. Reset 0.
- 0x18, LED (RW, 10 bits). Reset 0.
- 0x1C, SWITCH (RO): {22'b0, Switch_sync}.
- 0x20, BUTTON (RO): {30'b0, ~Button_1_sync, ~Button_0_sync}, i.e. 1 = pressed.
- Unused upper bits read 0.

Outputs:
- SEG7_n is a combinational decode of its register.
- Enable = 0 → 7'h7F (blank). This is the reset value of every display.
- Decode for digits 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
- LED equals the LED register directly; reset value 0.
- No output goes X after reset.

Test Plan:
- Hold RstQnnnH=1 for 8 cycles, then release -> all SEG7_n=7'h7F, LED=0, CR reads 0 at offsets 0x00–0x18.
- Backdoor-load a test into i_mem/d_mem of gpc_4t_tile_1, release reset -> tile executes; d_mem dump from SIZE_SHRD_MEM to SIZE_D_MEM matches the test's golden snapshot.
- CR write 0x1A to offset 0x00 -> next cycle SEG7_0=7'h08; write 0x0A -> SEG7_0=7'h7F; write 0x13 to 0x14 -> SEG7_5=7'h30.
- CR write 0xFFFF_FFFF to 0x18 -> LED=10'h3FF; read 0x18 returns 0x3FF one cycle after CrRdEn.
- Switch=10'h2A5 -> read at 0x1C returns 0x2A5 once ≥2 cycles have elapsed; Button_1=0 -> read at 0x20 returns 0x2.
- LED=0x155 set, then pulse Button_0=0 for 3 cycles -> 2 cycles after the press LED=0 and all SEG7 blank; tile restarts from its reset PC.

Source files
------------

// File: rtl/lotr_top.sv
// LOTR FPGA top: one 4-thread RV32I tile plus the board control-register block.
// The tile, its byte-wide memories and the shared geometry package live alongside.

package lotr_pkg;
   parameter logic [31:0] I_MEM_OFFSET  = 32'h0000_0000;
   parameter logic [31:0] SIZE_I_MEM    = 32'h0000_0400;
   parameter logic [31:0] D_MEM_OFFSET  = 32'h0000_0400;
   parameter logic [31:0] SIZE_D_MEM    = 32'h0000_0400;
   parameter logic [31:0] SIZE_SHRD_MEM = 32'h0000_0100;
endpackage

module byte_mem #(parameter int SIZE = 1024) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [$clog2(SIZE)-3:0] wr_word,
   input  logic [31:0]             wr_data,
   input  logic [$clog2(SIZE)-3:0] rd_word,
   output logic [31:0]             rd_data
);
   logic [7:0] mem      [0:SIZE-1];
   logic [7:0] next_mem [0:SIZE-1];

   // Next-state image: current contents with the pending little-endian word merged in
   always_comb begin
      next_mem = mem;
      if (we) begin
         for (int i = 0; i < 4; i++) next_mem[{wr_word, 2'(i)}] = wr_data[8*i +: 8];
      end else begin
         next_mem = mem;
      end
   end

   // Asynchronous word read
   always_comb begin
      rd_data = 32'd0;
      for (int i = 0; i < 4; i++) rd_data[8*i +: 8] = mem[{rd_word, 2'(i)}];
   end

   // Storage update; contents survive reset
   always_ff @(posedge clk) mem <= next_mem;
endmodule

module gpc_i_mem_wrap #(parameter int SIZE = 1024) (
   input  logic                    clk,
   input  logic [$clog2(SIZE)-3:0] rd_word,
   output logic [31:0]             rd_data
);
   byte_mem #(.SIZE(SIZE)) i_mem (.clk(clk), .we(1'b0), .wr_word('0), .wr_data(32'd0),
                                  .rd_word(rd_word), .rd_data(rd_data));
endmodule

module gpc_d_mem_wrap #(parameter int SIZE = 1024) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [$clog2(SIZE)-3:0] wr_word,
   input  logic [31:0]             wr_data,
   input  logic [$clog2(SIZE)-3:0] rd_word,
   output logic [31:0]             rd_data
);
   byte_mem #(.SIZE(SIZE)) d_mem (.clk(clk), .we(we), .wr_word(wr_word), .wr_data(wr_data),
                                  .rd_word(rd_word), .rd_data(rd_data));
endmodule

module gpc_4t_core
   import lotr_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] cr_addr,
   output logic        cr_wr_en,
   output logic [31:0] cr_wr_data,
   output logic        cr_rd_en,
   input  logic [31:0] cr_rd_data
);
   localparam int IAW = $clog2(SIZE_I_MEM);
   localparam int DAW = $clog2(SIZE_D_MEM);
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;

   typedef enum logic [1:0] {S_EXEC = 2'd0, S_RD = 2'd1, S_WB = 2'd2} state_t;

   state_t      state_r;
   logic [1:0]  tid_r;
   logic [31:0] pc_r [0:3];
   logic [31:0] rf_r [0:127];
   logic [4:0]  ld_rd_r;
   logic [31:0] ld_addr_r;
   logic        ld_cr_r;

   logic [31:0] instr_s, rs1_val_s, rs2_val_s, imm_i_s, imm_s_s, imm_u_s, imm_j_s;
   logic [31:0] mem_addr_s, d_rd_data_s;
   logic [6:0]  opcode_s;
   logic [4:0]  rd_s, rs1_s, rs2_s;
   logic [2:0]  funct3_s;
   logic        is_dmem_s, d_we_s;

   assign opcode_s   = instr_s[6:0];
   assign rd_s       = instr_s[11:7];
   assign funct3_s   = instr_s[14:12];
   assign rs1_s      = instr_s[19:15];
   assign rs2_s      = instr_s[24:20];
   assign imm_i_s    = {{20{instr_s[31]}}, instr_s[31:20]};
   assign imm_s_s    = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
   assign imm_u_s    = {instr_s[31:12], 12'd0};
   assign imm_j_s    = {{12{instr_s[31]}}, instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
   assign rs1_val_s  = (rs1_s == 5'd0) ? 32'd0 : rf_r[{tid_r, rs1_s}];
   assign rs2_val_s  = (rs2_s == 5'd0) ? 32'd0 : rf_r[{tid_r, rs2_s}];
   assign mem_addr_s = rs1_val_s + ((opcode_s == OP_STORE) ? imm_s_s : imm_i_s);
   assign is_dmem_s  = (mem_addr_s >= D_MEM_OFFSET) && (mem_addr_s < (D_MEM_OFFSET + SIZE_D_MEM));
   assign d_we_s     = (state_r == S_EXEC) && (opcode_s == OP_STORE) && is_dmem_s;

   gpc_i_mem_wrap #(.SIZE(int'(SIZE_I_MEM))) i_mem_wrap (
      .clk(clk), .rd_word((IAW-2)'((pc_r[tid_r] - I_MEM_OFFSET) >> 2)), .rd_data(instr_s));

   gpc_d_mem_wrap #(.SIZE(int'(SIZE_D_MEM))) d_mem_wrap (
      .clk(clk), .we(d_we_s), .wr_word((DAW-2)'((mem_addr_s - D_MEM_OFFSET) >> 2)),
      .wr_data(rs2_val_s), .rd_word((DAW-2)'((ld_addr_r - D_MEM_OFFSET) >> 2)),
      .rd_data(d_rd_data_s));

   // Barrel sequencer: threads take turns, a load holds its turn until write-back
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_EXEC;
         tid_r      <= 2'd0;
         for (int t = 0; t < 4; t++) pc_r[t] <= I_MEM_OFFSET + (32'(t) << 8);
         cr_addr    <= 32'd0;
         cr_wr_en   <= 1'b0;
         cr_wr_data <= 32'd0;
         cr_rd_en   <= 1'b0;
         ld_rd_r    <= 5'd0;
         ld_addr_r  <= 32'd0;
         ld_cr_r    <= 1'b0;
      end else begin
         cr_wr_en <= 1'b0;
         cr_rd_en <= 1'b0;
         case (state_r)
            S_EXEC: begin
               pc_r[tid_r] <= pc_r[tid_r] + 32'd4;
               tid_r       <= tid_r + 2'd1;
               case (opcode_s)
                  OP_LUI: rf_r[{tid_r, rd_s}] <= imm_u_s;
                  OP_IMM: if (funct3_s == 3'd0) rf_r[{tid_r, rd_s}] <= rs1_val_s + imm_i_s;
                  OP_JAL: begin
                     rf_r[{tid_r, rd_s}] <= pc_r[tid_r] + 32'd4;
                     pc_r[tid_r]         <= pc_r[tid_r] + imm_j_s;
                  end
                  OP_STORE: if (!is_dmem_s) begin
                     cr_wr_en   <= 1'b1;
                     cr_addr    <= mem_addr_s;
                     cr_wr_data <= rs2_val_s;
                  end
                  OP_LOAD: begin
                     ld_rd_r   <= rd_s;
                     ld_addr_r <= mem_addr_s;
                     ld_cr_r   <= !is_dmem_s;
                     tid_r     <= tid_r;
                     state_r   <= S_RD;
                     if (!is_dmem_s) begin
                        cr_rd_en <= 1'b1;
                        cr_addr  <= mem_addr_s;
                     end
                  end
                  default: ;
               endcase
            end
            S_RD: state_r <= S_WB;
            S_WB: begin
               rf_r[{tid_r, ld_rd_r}] <= ld_cr_r ? cr_rd_data : d_rd_data_s;
               tid_r   <= tid_r + 2'd1;
               state_r <= S_EXEC;
            end
            default: state_r <= S_EXEC;
         endcase
      end
   end
endmodule

module gpc_4t_tile (
   input  logic        QClk,
   input  logic        RstQnnnH,
   output logic [31:0] CrAddr,
   output logic        CrWrEn,
   output logic [31:0] CrWrData,
   output logic        CrRdEn,
   input  logic [31:0] CrRdData
);
   gpc_4t_core gpc_4t (.clk(QClk), .rst(RstQnnnH), .cr_addr(CrAddr), .cr_wr_en(CrWrEn),
                       .cr_wr_data(CrWrData), .cr_rd_en(CrRdEn), .cr_rd_data(CrRdData));
endmodule

module lotr_top
   import lotr_pkg::*;
#(
   parameter logic [31:0] CR_BASE  = 32'h00C0_0000,
   parameter int          NUM_SEG7 = 6,
   parameter int          LED_W    = 10
) (
   input  logic             QClk,
   input  logic             RstQnnnH,
   input  logic             Button_0,
   input  logic             Button_1,
   input  logic [LED_W-1:0] Switch,
   output logic [6:0]       SEG7_0,
   output logic [6:0]       SEG7_1,
   output logic [6:0]       SEG7_2,
   output logic [6:0]       SEG7_3,
   output logic [6:0]       SEG7_4,
   output logic [6:0]       SEG7_5,
   output logic [LED_W-1:0] LED
);
   logic [1:0]       button_0_sync_r, button_1_sync_r;
   logic [LED_W-1:0] switch_meta_r, switch_sync_r;
   logic [4:0]       seg_r [0:NUM_SEG7-1];
   logic [LED_W-1:0] led_r;
   logic [31:0]      cr_rd_data_r, rd_mux_s, cr_addr_s, cr_wr_data_s;
   logic             cr_wr_en_s, cr_rd_en_s, cr_hit_s, rst_int_s, unused_s;
   logic [5:0]       cr_idx_s;

   function automatic logic [6:0] seg7_decode(input logic [4:0] r);
      logic [6:0] d;
      case (r[3:0])
         4'h0: d = 7'h40;  4'h1: d = 7'h79;  4'h2: d = 7'h24;  4'h3: d = 7'h30;
         4'h4: d = 7'h19;  4'h5: d = 7'h12;  4'h6: d = 7'h02;  4'h7: d = 7'h78;
         4'h8: d = 7'h00;  4'h9: d = 7'h10;  4'hA: d = 7'h08;  4'hB: d = 7'h03;
         4'hC: d = 7'h46;  4'hD: d = 7'h21;  4'hE: d = 7'h06;  4'hF: d = 7'h0E;
         default: d = 7'h7F;
      endcase
      return r[4] ? d : 7'h7F;
   endfunction

   gpc_4t_tile gpc_4t_tile_1 (
      .QClk(QClk), .RstQnnnH(rst_int_s), .CrAddr(cr_addr_s), .CrWrEn(cr_wr_en_s),
      .CrWrData(cr_wr_data_s), .CrRdEn(cr_rd_en_s), .CrRdData(cr_rd_data_r));

   assign rst_int_s = RstQnnnH | ~button_0_sync_r[1];
   assign cr_hit_s  = (cr_addr_s[31:8] == CR_BASE[31:8]);
   assign cr_idx_s  = cr_addr_s[7:2];
   assign unused_s  = &{1'b0, cr_addr_s[1:0], cr_wr_data_s[31:LED_W]};

   // Board input synchronisers; only the board reset clears them, so Button_0 cannot lock itself
   always_ff @(posedge QClk) begin
      if (RstQnnnH) begin
         button_0_sync_r <= 2'b11;
         button_1_sync_r <= 2'b11;
         switch_meta_r   <= '0;
         switch_sync_r   <= '0;
      end else begin
         button_0_sync_r <= {button_0_sync_r[0], Button_0};
         button_1_sync_r <= {button_1_sync_r[0], Button_1};
         switch_meta_r   <= Switch;
         switch_sync_r   <= switch_meta_r;
      end
   end

   // CR read mux, decoded on word address
   always_comb begin
      rd_mux_s = 32'd0;
      if (cr_hit_s) begin
         case (cr_idx_s)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: rd_mux_s = {27'd0, seg_r[cr_idx_s[2:0]]};
            6'd6:    rd_mux_s = {{(32-LED_W){1'b0}}, led_r};
            6'd7:    rd_mux_s = {{(32-LED_W){1'b0}}, switch_sync_r};
            6'd8:    rd_mux_s = {30'd0, ~button_1_sync_r[1], ~button_0_sync_r[1]};
            default: rd_mux_s = 32'd0;
         endcase
      end else begin
         rd_mux_s = 32'd0;
      end
   end

   // CR registers and registered read data (a same-cycle write is seen by the next read)
   always_ff @(posedge QClk) begin
      if (rst_int_s) begin
         for (int i = 0; i < NUM_SEG7; i++) seg_r[i] <= 5'd0;
         led_r        <= '0;
         cr_rd_data_r <= 32'd0;
      end else begin
         if (cr_wr_en_s && cr_hit_s) begin
            case (cr_idx_s)
               6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: seg_r[cr_idx_s[2:0]] <= cr_wr_data_s[4:0];
               6'd6:    led_r <= cr_wr_data_s[LED_W-1:0];
               default: ;
            endcase
         end
         cr_rd_data_r <= cr_rd_en_s ? rd_mux_s : 32'd0;
      end
   end

   assign SEG7_0 = seg7_decode(seg_r[0]);
   assign SEG7_1 = seg7_decode(seg_r[1]);
   assign SEG7_2 = seg7_decode(seg_r[2]);
   assign SEG7_3 = seg7_decode(seg_r[3]);
   assign SEG7_4 = seg7_decode(seg_r[4]);
   assign SEG7_5 = seg7_decode(seg_r[5]);
   assign LED    = led_r;
endmodule

// File: tb/tb_lotr_top.sv
// Self-checking bench for lotr_top: backdoor-loaded RV32I programs drive the CR block,
// results are checked on the board outputs and in the d_mem snapshot.

module tb_lotr_top;
   logic       QClk = 1'b0;
   logic       RstQnnnH, Button_0, Button_1;
   logic [9:0] Switch;
   logic [6:0] SEG7_0, SEG7_1, SEG7_2, SEG7_3, SEG7_4, SEG7_5;
   logic [9:0] LED;

   localparam int DSIZE   = 1024;
   localparam int SHRD    = 256;
   localparam int MAX_OPS = 32;

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0]  seg_tbl [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [4:0]  m_seg [0:5];
   logic [9:0]  m_led;
   logic [31:0] exp_rd [$];
   bit          op_rd  [0:MAX_OPS-1];
   logic [31:0] op_off [0:MAX_OPS-1];
   logic [31:0] op_val [0:MAX_OPS-1];
   int          n_ops;

   always #5 QClk = ~QClk;

   lotr_top dut (
      .QClk(QClk), .RstQnnnH(RstQnnnH), .Button_0(Button_0), .Button_1(Button_1),
      .Switch(Switch), .SEG7_0(SEG7_0), .SEG7_1(SEG7_1), .SEG7_2(SEG7_2),
      .SEG7_3(SEG7_3), .SEG7_4(SEG7_4), .SEG7_5(SEG7_5), .LED(LED));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
      return {imm, rd, 7'b0110111};
   endfunction
   function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b010, rd, 7'b0000011};
   endfunction

   function automatic logic [6:0] exp_seg(input logic [4:0] r);
      return r[4] ? seg_tbl[r[3:0]] : 7'h7F;
   endfunction

   function automatic logic [6:0] seg_out(input int i);
      case (i)
         0: return SEG7_0;
         1: return SEG7_1;
         2: return SEG7_2;
         3: return SEG7_3;
         4: return SEG7_4;
         default: return SEG7_5;
      endcase
   endfunction

   task automatic wr_imem(input int a, input logic [31:0] w);
      for (int b = 0; b < 4; b++) dut.gpc_4t_tile_1.gpc_4t.i_mem_wrap.i_mem.mem[a+b] = w[8*b +: 8];
   endtask

   function automatic logic [31:0] rd_dmem(input int a);
      logic [31:0] w;
      for (int b = 0; b < 4; b++) w[8*b +: 8] = dut.gpc_4t_tile_1.gpc_4t.d_mem_wrap.d_mem.mem[a+b];
      return w;
   endfunction

   // Reference behaviour of the CR window as seen by software
   function automatic logic [31:0] model_read(input logic [31:0] off);
      int idx;
      idx = int'(off >> 2);
      if (off >= 32'h100) return 32'd0;
      if (idx < 6) return {27'd0, m_seg[idx]};
      if (idx == 6) return {22'd0, m_led};
      if (idx == 7) return {22'd0, Switch};
      if (idx == 8) return {30'd0, ~Button_1, 1'b0};
      return 32'd0;
   endfunction

   task automatic model_write(input logic [31:0] off, input logic [31:0] v);
      int idx;
      idx = int'(off >> 2);
      if (off < 32'h100) begin
         if (idx < 6) m_seg[idx] = v[4:0];
         else if (idx == 6) m_led = v[9:0];
      end
   endtask

   // Emit thread-0 program from the op list while updating the reference model
   task automatic build_program();
      int pc, nr;
      pc = 0;
      nr = 0;
      for (int i = 0; i < 6; i++) m_seg[i] = 5'd0;
      m_led = 10'd0;
      exp_rd.delete();
      wr_imem(pc, enc_lui(5'd1, 20'h00C00));       pc += 4;
      wr_imem(pc, enc_addi(5'd4, 5'd0, 12'h500));  pc += 4;
      for (int k = 0; k < n_ops; k++) begin
         if (op_rd[k]) begin
            wr_imem(pc, enc_lw(5'd3, 5'd1, 12'(op_off[k])));        pc += 4;
            wr_imem(pc, enc_sw(5'd3, 5'd4, 12'(nr * 4)));           pc += 4;
            exp_rd.push_back(model_read(op_off[k]));
            nr++;
         end else begin
            wr_imem(pc, enc_addi(5'd2, 5'd0, op_val[k][11:0]));      pc += 4;
            wr_imem(pc, enc_sw(5'd2, 5'd1, 12'(op_off[k])));         pc += 4;
            model_write(op_off[k], op_val[k]);
         end
      end
      wr_imem(pc, enc_addi(5'd5, 5'd0, 12'h5A5)); pc += 4;
      wr_imem(pc, enc_addi(5'd6, 5'd0, 12'h400)); pc += 4;
      wr_imem(pc, enc_sw(5'd5, 5'd6, 12'h000));   pc += 4;
      wr_imem(pc, 32'h0000_006F);
      for (int t = 1; t < 4; t++) wr_imem(t * 256, 32'h0000_006F);
   endtask

   task automatic start_round(input string tag);
      @(negedge QClk);
      RstQnnnH = 1'b1;
      build_program();
      for (int i = 0; i < DSIZE; i++) dut.gpc_4t_tile_1.gpc_4t.d_mem_wrap.d_mem.mem[i] = 8'h00;
      repeat (8) @(posedge QClk);
      @(negedge QClk);
      RstQnnnH = 1'b0;
      @(posedge QClk); #1;
      for (int i = 0; i < 6; i++) check_eq($sformatf("%s_rst_seg%0d", tag, i), {25'd0, seg_out(i)}, 32'h7F);
      check_eq({tag, "_rst_led"}, {22'd0, LED}, 32'd0);
   endtask

   task automatic finish_round(input string tag);
      logic [31:0] mk;
      int cyc;
      mk  = 32'd0;
      cyc = 0;
      while (mk != 32'h5A5 && cyc < 3000) begin
         @(posedge QClk); #1;
         mk = rd_dmem(0);
         cyc++;
      end
      check_eq({tag, "_done"}, mk, 32'h5A5);
      repeat (4) @(posedge QClk); #1;
      for (int i = 0; i < 6; i++)
         check_eq($sformatf("%s_seg%0d", tag, i), {25'd0, seg_out(i)}, {25'd0, exp_seg(m_seg[i])});
      check_eq({tag, "_led"}, {22'd0, LED}, {22'd0, m_led});
      for (int a = SHRD; a < DSIZE; a += 4) begin
         int k;
         k = (a - SHRD) / 4;
         check_eq($sformatf("%s_dmem_%03h", tag, a), rd_dmem(a), (k < exp_rd.size()) ? exp_rd[k] : 32'd0);
      end
   endtask

   task automatic add_op(input bit rd, input logic [31:0] off, input logic [11:0] v);
      op_rd[n_ops]  = rd;
      op_off[n_ops] = off;
      op_val[n_ops] = {{20{v[11]}}, v};
      n_ops++;
   endtask

   initial begin
      RstQnnnH = 1'b1;
      Button_0 = 1'b1;
      Button_1 = 1'b1;
      Switch   = 10'd0;

      // Directed round: reset reads, decode and LED width cases, switch/button reads
      n_ops = 0;
      for (int i = 0; i < 7; i++) add_op(1'b1, 32'(i * 4), 12'd0);
      add_op(1'b0, 32'h00, 12'h01A);
      add_op(1'b0, 32'h04, 12'h00A);
      add_op(1'b0, 32'h14, 12'h013);
      add_op(1'b0, 32'h18, 12'hFFF);
      add_op(1'b1, 32'h18, 12'd0);
      add_op(1'b1, 32'h1C, 12'd0);
      add_op(1'b1, 32'h20, 12'd0);
      add_op(1'b1, 32'h00, 12'd0);
      add_op(1'b1, 32'h24, 12'd0);
      Switch   = 10'h2A5;
      Button_1 = 1'b0;
      start_round("dir");
      finish_round("dir");

      // Button_0 press resets the CR block and restarts the tile
      @(negedge QClk);
      Button_0 = 1'b0;
      repeat (3) @(posedge QClk); #1;
      check_eq("btn0_led", {22'd0, LED}, 32'd0);
      for (int i = 0; i < 6; i++) check_eq($sformatf("btn0_seg%0d", i), {25'd0, seg_out(i)}, 32'h7F);
      for (int b = 0; b < 4; b++) dut.gpc_4t_tile_1.gpc_4t.d_mem_wrap.d_mem.mem[b] = 8'h00;
      @(negedge QClk);
      Button_0 = 1'b1;
      finish_round("btn0_rerun");

      // Randomised rounds
      for (int r = 0; r < 4; r++) begin
         n_ops = 24;
         for (int k = 0; k < n_ops; k++) begin
            logic [31:0] base;
            int sel;
            base = 32'($urandom_range(0, 8) * 4);
            sel  = int'($urandom_range(0, 9));
            op_rd[k]  = ($urandom_range(0, 1) == 1);
            op_val[k] = 32'($urandom_range(0, 4095));
            op_val[k] = {{20{op_val[k][11]}}, op_val[k][11:0]};
            case (sel)
               0:       op_off[k] = (($urandom_range(0, 1) == 1) ? 32'h100 : 32'h7FC);
               1:       op_off[k] = (($urandom_range(0, 1) == 1) ? 32'h24 : 32'hFC);
               2:       op_off[k] = base + 32'($urandom_range(1, 3));
               default: op_off[k] = base;
            endcase
         end
         Switch   = 10'($urandom_range(0, 1023));
         Button_1 = 1'($urandom_range(0, 1));
         start_round($sformatf("rnd%0d", r));
         finish_round($sformatf("rnd%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
